// File: rtl/if_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : if_fetch_unit
// Brief    : IF stage: PC, req/ack imem fetch, IF/ID register, redirect/stall.
//            Optional IF_PERF_CNT_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
// =============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        fetch_bubble
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] skid, skid_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] id_inst_nxt, id_pc4_nxt;
    logic        id_valid_nxt;
    logic        running;
    logic        redir;
    logic [31:0] tgt_raw, tgt, pc_plus4;

    assign redir    = !stall && ((pcsource == 2'b01) || (pcsource == 2'b10));
    assign tgt_raw  = (pcsource == 2'b10) ? jpc : bpc;
    assign tgt      = tgt_raw & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    // running keeps imem_req low while clrn is asserted and for the reset cycle itself
    assign imem_req     = running && (state != HOLD);
    assign imem_addr    = (state == DROP) ? drop_addr : pc;
    assign fetch_bubble = (state != FETCH) || !imem_ack || redir;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        skid_nxt      = skid;
        drop_addr_nxt = drop_addr;
        id_inst_nxt   = id_inst;
        id_pc4_nxt    = id_pc4;
        id_valid_nxt  = id_valid;

        if (redir) begin
            pc_nxt       = tgt;
            id_inst_nxt  = NOP_INST;
            id_valid_nxt = 1'b0;
        end

        case (state)
            FETCH: begin
                if (redir) begin
                    // request still in flight: finish it at the old address, then discard
                    if (!imem_ack) begin
                        state_nxt     = DROP;
                        drop_addr_nxt = pc;
                    end
                end else if (imem_ack && stall) begin
                    skid_nxt  = imem_rdata;
                    state_nxt = HOLD;
                end else if (imem_ack) begin
                    id_inst_nxt  = imem_rdata;
                    id_pc4_nxt   = pc_plus4;
                    id_valid_nxt = 1'b1;
                    pc_nxt       = pc_plus4;
                end else if (!stall) begin
                    id_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nxt = FETCH;
                    if (!redir) begin
                        id_inst_nxt  = skid;
                        id_pc4_nxt   = pc_plus4;
                        id_valid_nxt = 1'b1;
                        pc_nxt       = pc_plus4;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
                if (!redir && !stall) begin
                    id_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            skid      <= '0;
            drop_addr <= '0;
            id_inst   <= NOP_INST;
            id_pc4    <= '0;
            id_valid  <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            skid      <= skid_nxt;
            drop_addr <= drop_addr_nxt;
            id_inst   <= id_inst_nxt;
            id_pc4    <= id_pc4_nxt;
            id_valid  <= id_valid_nxt;
            running   <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redir && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Scoreboard bench: random-latency imem model, random stall/redirect,
//            expected instruction stream kept as a queue of fetch addresses.
// Revision : 1.0 - initial release
// =============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        fetch_bubble;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .stall(stall),
        .pcsource(pcsource),
        .bpc(bpc),
        .jpc(jpc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .id_inst(id_inst),
        .id_pc4(id_pc4),
        .id_valid(id_valid),
        .fetch_bubble(fetch_bubble)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int lat_min = 0;
    int lat_max = 0;
    int n_deliv = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory model ----------------
    initial begin
        int          cnt;
        logic        busy;
        logic [31:0] held;
        busy = 1'b0;
        cnt  = 0;
        held = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!clrn || !imem_req) begin
                imem_ack = 1'b0;
                busy     = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = int'($urandom_range(lat_max, lat_min));
                    held = imem_addr;
                end else begin
                    check("addr_stable", imem_addr, held);
                end
                check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memword(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    cnt--;
                end
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    // exp_q holds the fetch addresses that must reach ID next, in order.
    logic [31:0] exp_q[$];

    function automatic void restart(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(a + 32'(4 * i));
    endfunction

    initial begin
        logic        have_prev, prev_stall, prev_redir, prev_fire, prev_valid;
        logic [31:0] prev_inst, prev_pc4, tgt_now, a;
        logic        newd, redir_now;
        int          idle;
        have_prev = 1'b0;
        prev_stall = 1'b0; prev_redir = 1'b0; prev_fire = 1'b0; prev_valid = 1'b0;
        prev_inst = '0; prev_pc4 = '0;
        idle = 0;
        restart(RESET_PC);
        forever begin
            @(negedge clk);
            if (!clrn) begin
                restart(RESET_PC);
                have_prev = 1'b0;
                idle      = 0;
            end else begin
                if (have_prev && prev_stall) begin
                    check("stall_hold_inst", id_inst, prev_inst);
                    check("stall_hold_pc4", id_pc4, prev_pc4);
                    check("stall_hold_valid", {31'b0, id_valid}, {31'b0, prev_valid});
                end
                if (have_prev && prev_redir) check("flush_valid", {31'b0, id_valid}, 32'd0);
                newd = id_valid && !(have_prev && prev_valid && (prev_pc4 == id_pc4));
                if (have_prev && prev_fire) check("ack_latency", {31'b0, newd}, 32'd1);
                if (newd) begin
                    exp_q.push_back(exp_q[$] + 32'd4);
                    a = exp_q.pop_front();
                    check("deliv_pc4", id_pc4, a + 32'd4);
                    check("deliv_inst", id_inst, memword(a));
                    idle = 0;
                    n_deliv++;
                end else begin
                    idle++;
                    if (idle > 60) begin
                        check("deliv_timeout", idle, 32'd0);
                        idle = 0;
                    end
                end
                redir_now = !stall && ((pcsource == 2'b01) || (pcsource == 2'b10));
                tgt_now   = (pcsource == 2'b10) ? jpc : bpc;
                tgt_now   = tgt_now & 32'hFFFF_FFFC;
                if (!imem_ack || redir_now) check("bubble", {31'b0, fetch_bubble}, 32'd1);
                if (redir_now) restart(tgt_now);
                prev_fire  = imem_ack && !stall && !redir_now && !fetch_bubble;
                prev_stall = stall;
                prev_redir = redir_now;
                prev_valid = id_valid;
                prev_inst  = id_inst;
                prev_pc4   = id_pc4;
                have_prev  = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_inst"}, id_inst, NOP_INST);
        check({tag, "_pc4"}, id_pc4, 32'd0);
        check({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return $urandom & 32'h0000_03FF;
            1:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
            2:       return $urandom;
            default: return $urandom & 32'h0000_00FC;
        endcase
    endfunction

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #6 clrn = 1'b1;

        // sequential fetch, 1-cycle memory
        cyc();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        #2 check("steady_bubble", {31'b0, fetch_bubble}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("seq_valid", {31'b0, id_valid}, 32'd1);
            check("seq_pc4", id_pc4, 32'(4 * i));
        end

        // stall on the fetch of 0x10 for two cycles
        for (int k = 0; k < 10 && !(imem_req && imem_addr == 32'h10); k++) cyc();
        check("t2_addr", imem_addr, 32'h10);
        stall = 1'b1;
        cyc();
        check("t2_hold1", id_pc4, 32'h10);
        cyc();
        check("t2_hold2", id_pc4, 32'h10);
        stall = 1'b0;
        cyc();
        check("t2_inst", id_inst, memword(32'h10));
        check("t2_pc4", id_pc4, 32'h14);
        check("t2_next", imem_addr, 32'h14);

        // branch with same-cycle ack
        pcsource = 2'b01; bpc = 32'h40;
        cyc();
        pcsource = 2'b00;
        check("t3_valid", {31'b0, id_valid}, 32'd0);
        check("t3_addr", imem_addr, 32'h40);

        // jump while a slow fetch at 0x20 is pending
        pcsource = 2'b10; jpc = 32'h20;
        cyc();
        pcsource = 2'b00;
        lat_min = 3; lat_max = 3;
        check("t4_start", imem_addr, 32'h20);
        pcsource = 2'b10; jpc = 32'h80;
        for (int j = 0; j < 3; j++) begin
            cyc();
            pcsource = 2'b00;
            check("t4_drop_addr", imem_addr, 32'h20);
            check("t4_drop_valid", {31'b0, id_valid}, 32'd0);
        end
        lat_min = 0; lat_max = 0;
        cyc();
        check("t4_new_addr", imem_addr, 32'h80);
        check("t4_no_valid", {31'b0, id_valid}, 32'd0);
        cyc();
        check("t4_pc4", id_pc4, 32'h84);

        // wrap at the top of the address space
        pcsource = 2'b10; jpc = 32'hFFFF_FFFC;
        cyc();
        pcsource = 2'b00;
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        check("t5_pc4", id_pc4, 32'h0);
        check("t5_inst", id_inst, memword(32'hFFFF_FFFC));
        check("t5_next", imem_addr, 32'h0);

        // asynchronous reset while in DROP
        lat_min = 3; lat_max = 3;
        cyc();
        pcsource = 2'b10; jpc = 32'h100;
        cyc();
        pcsource = 2'b00;
        check("t6_drop_addr", imem_addr, 32'h0);
        #2 clrn = 1'b0;
        #1 check_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        #7 clrn = 1'b1;
        lat_min = 0; lat_max = 0;
        cyc();
        check("t6_req", {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, RESET_PC);

        // randomized traffic
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(3) == 0);
            r = int'($urandom_range(15));
            if (r < 2)       pcsource = 2'b01;
            else if (r < 4)  pcsource = 2'b10;
            else if (r == 4) pcsource = 2'b11;
            else             pcsource = 2'b00;
            if (stall && pcsource != 2'b00 && $urandom_range(3) != 0) pcsource = 2'b00;
            bpc = pick_target();
            jpc = pick_target();
            if (i == 1500) begin
                #2 clrn = 1'b0;
                #1 check_reset_outputs("mid_rst");
                @(posedge clk);
                #7 clrn = 1'b1;
            end
        end
        stall = 1'b0;
        pcsource = 2'b00;
        repeat (10) cyc();
        check("deliv_count", {31'b0, (n_deliv > 500)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
